// File: rtl/id_ex_stage.sv
// Elastic decode-to-execute pipeline register with optional two-entry skid buffer.
// Invalid entries always present all-zero control so bubbles can never commit side effects.
module id_ex_stage #(
    parameter int DATA_W = 160,
    parameter int CTRL_W = 16,
    parameter bit SKID   = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;

    logic main_v;
    logic skid_v;
    logic in_xfer;
    logic out_xfer;

    assign main_v = (state_q != EMPTY);
    assign skid_v = (state_q == FULL);

    // With the skid buffer, ready depends only on registered state.
    assign in_ready = SKID ? !skid_v : (!main_v || out_ready);

    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = main_v && out_ready;

    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_ctrl_d = main_ctrl_q;
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;

        if (flush) begin
            state_d     = EMPTY;
            main_ctrl_d = '0;
            skid_ctrl_d = '0;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_xfer) begin
                        state_d     = ONE;
                        main_data_d = in_data;
                        main_ctrl_d = in_ctrl;
                    end
                end
                ONE: begin
                    if (in_xfer && out_xfer) begin
                        main_data_d = in_data;
                        main_ctrl_d = in_ctrl;
                    end else if (in_xfer && SKID) begin
                        state_d     = FULL;
                        skid_data_d = in_data;
                        skid_ctrl_d = in_ctrl;
                    end else if (out_xfer) begin
                        state_d     = EMPTY;
                        main_ctrl_d = '0;
                    end
                end
                FULL: begin
                    if (out_xfer) begin
                        state_d     = ONE;
                        main_data_d = skid_data_q;
                        main_ctrl_d = skid_ctrl_q;
                        skid_ctrl_d = '0;
                    end
                end
                default: begin
                    state_d     = EMPTY;
                    main_ctrl_d = '0;
                    skid_ctrl_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= EMPTY;
            main_data_q <= '0;
            main_ctrl_q <= '0;
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_ctrl_q <= main_ctrl_d;
            skid_data_q <= skid_data_d;
            skid_ctrl_q <= skid_ctrl_d;
        end
    end

    assign out_valid = main_v;
    assign out_data  = main_data_q;
    assign out_ctrl  = main_v ? main_ctrl_q : '0;
    assign occupancy = {1'b0, main_v} + {1'b0, skid_v};

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: skid and non-skid instances share stimulus and are
// each compared against a bounded FIFO reference model.
module tb_id_ex_stage;

    localparam int DW = 160;
    localparam int CW = 16;
    localparam int EW = DW + CW;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_ctrl;
    logic          flush;
    logic          out_ready;

    logic          ir1, ov1, ir0, ov0;
    logic [DW-1:0] od1, od0;
    logic [CW-1:0] oc1, oc0;
    logic [1:0]    occ1, occ0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [EW-1:0] q1[$];
    logic [EW-1:0] q0[$];

    always #5 clk = ~clk;

    id_ex_stage #(.DATA_W(DW), .CTRL_W(CW), .SKID(1'b1)) u_dut1 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(ir1),
        .in_data(in_data), .in_ctrl(in_ctrl),
        .flush(flush),
        .out_valid(ov1), .out_ready(out_ready),
        .out_data(od1), .out_ctrl(oc1),
        .occupancy(occ1)
    );

    id_ex_stage #(.DATA_W(DW), .CTRL_W(CW), .SKID(1'b0)) u_dut0 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(ir0),
        .in_data(in_data), .in_ctrl(in_ctrl),
        .flush(flush),
        .out_valid(ov0), .out_ready(out_ready),
        .out_data(od0), .out_ctrl(oc0),
        .occupancy(occ0)
    );

    task automatic chk(input string tag, input logic [EW-1:0] obs,
                       input logic [EW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rnd_data();
        return {$urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check_outputs();
        chk("s1_out_valid", ov1, q1.size() != 0);
        chk("s1_occupancy", occ1, q1.size());
        chk("s1_out_ctrl", oc1, (q1.size() != 0) ? q1[0][CW-1:0] : '0);
        if (q1.size() != 0) chk("s1_out_data", od1, q1[0][EW-1:CW]);
        chk("s0_out_valid", ov0, q0.size() != 0);
        chk("s0_occupancy", occ0, q0.size());
        chk("s0_out_ctrl", oc0, (q0.size() != 0) ? q0[0][CW-1:0] : '0);
        if (q0.size() != 0) chk("s0_out_data", od0, q0[0][EW-1:CW]);
    endtask

    // Drive one cycle, check ready before the edge, update models, check after.
    task automatic step(input logic iv, input logic [DW-1:0] d,
                        input logic [CW-1:0] c, input logic fl,
                        input logic ordy);
        logic e_ir1, e_ir0;
        in_valid  = iv;
        in_data   = d;
        in_ctrl   = c;
        flush     = fl;
        out_ready = ordy;
        #1;
        e_ir1 = (q1.size() < 2);
        e_ir0 = (q0.size() == 0) || ordy;
        chk("s1_in_ready", ir1, e_ir1);
        chk("s0_in_ready", ir0, e_ir0);
        @(posedge clk);
        if (fl) begin
            q1.delete();
            q0.delete();
        end else begin
            if (q1.size() != 0 && ordy) void'(q1.pop_front());
            if (iv && e_ir1) q1.push_back({d, c});
            if (q0.size() != 0 && ordy) void'(q0.pop_front());
            if (iv && e_ir0) q0.push_back({d, c});
        end
        #1;
        check_outputs();
    endtask

    initial begin
        logic [DW-1:0] a, i2;
        logic [CW-1:0] c2;

        // Reset with an aggressive offer on the input
        reset     = 1'b0;
        in_valid  = 1'b1;
        in_ctrl   = 16'hFFFF;
        in_data   = rnd_data();
        flush     = 1'b0;
        out_ready = 1'b0;
        #17;
        chk("rst_s1_out_valid", ov1, 1'b0);
        chk("rst_s1_out_ctrl", oc1, '0);
        chk("rst_s1_out_data", od1, '0);
        chk("rst_s1_occupancy", occ1, 2'd0);
        chk("rst_s1_in_ready", ir1, 1'b1);
        chk("rst_s0_out_valid", ov0, 1'b0);
        chk("rst_s0_out_ctrl", oc0, '0);
        chk("rst_s0_occupancy", occ0, 2'd0);
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_outputs();

        // First transfer after reset
        a = rnd_data();
        step(1'b1, a, 16'h1234, 1'b0, 1'b1);
        chk("first_out_data", od1, a);
        chk("first_out_valid", ov1, 1'b1);

        // Streaming
        for (int i = 0; i < 8; i++)
            step(1'b1, rnd_data(), 16'($urandom), 1'b0, 1'b1);
        step(1'b0, rnd_data(), 16'h0, 1'b0, 1'b1);

        // Backpressure fills the skid entry; I2 is held by the source
        step(1'b1, rnd_data(), 16'hA001, 1'b0, 1'b0);
        step(1'b1, rnd_data(), 16'hA002, 1'b0, 1'b0);
        i2 = rnd_data();
        c2 = 16'hA003;
        step(1'b1, i2, c2, 1'b0, 1'b0);
        chk("bp_occupancy", occ1, 2'd2);
        chk("bp_in_ready", ir1, 1'b0);
        step(1'b1, i2, c2, 1'b0, 1'b1);
        step(1'b1, i2, c2, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++)
            step(1'b0, rnd_data(), 16'h0, 1'b0, 1'b1);

        // Flush with both entries holding live control
        step(1'b1, rnd_data(), 16'h00FF, 1'b0, 1'b0);
        step(1'b1, rnd_data(), 16'h00FF, 1'b0, 1'b0);
        chk("pre_flush_occ", occ1, 2'd2);
        step(1'b1, rnd_data(), 16'hBEEF, 1'b1, 1'b0);
        chk("flush_occ", occ1, 2'd0);
        chk("flush_ctrl", oc1, '0);
        step(1'b0, rnd_data(), 16'h0, 1'b0, 1'b1);
        step(1'b0, rnd_data(), 16'h0, 1'b0, 1'b1);

        // Non-skid ready follows out_ready combinationally
        step(1'b1, rnd_data(), 16'h0C01, 1'b0, 1'b0);
        step(1'b1, rnd_data(), 16'h0C02, 1'b0, 1'b0);
        chk("s0_stall_ready", ir0, 1'b0);
        step(1'b1, rnd_data(), 16'h0C03, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++)
            step(1'b0, rnd_data(), 16'h0, 1'b0, 1'b1);

        // Asynchronous reset while full
        step(1'b1, rnd_data(), 16'h0D01, 1'b0, 1'b0);
        step(1'b1, rnd_data(), 16'h0D02, 1'b0, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_s1_out_valid", ov1, 1'b0);
        chk("arst_s1_out_ctrl", oc1, '0);
        chk("arst_s1_occupancy", occ1, 2'd0);
        chk("arst_s1_in_ready", ir1, 1'b1);
        chk("arst_s0_out_valid", ov0, 1'b0);
        q1.delete();
        q0.delete();
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_outputs();

        // Random traffic
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 3) != 0), rnd_data(), 16'($urandom),
                 1'($urandom_range(0, 15) == 0),
                 1'($urandom_range(0, 2) != 0));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
